// File: rtl/rc4_ksa_engine_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine.
// Used by rc4_ksa_engine, its key-byte selector and its bus interface.
package rc4_pkg;

  localparam int S_SIZE            = 256;
  localparam int KEY_BYTES_DEFAULT = 3;

  typedef logic [7:0] key_byte_t;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FILL  = 4'd1,
    ST_RD_I  = 4'd2,
    ST_WT_I  = 4'd3,
    ST_CAP_I = 4'd4,
    ST_RD_J  = 4'd5,
    ST_WT_J  = 4'd6,
    ST_CAP_J = 4'd7,
    ST_WR_J  = 4'd8,
    ST_WR_I  = 4'd9,
    ST_DONE  = 4'd10
  } ksa_state_t;

  // A run is in flight in every state except the two resting ones.
  function automatic logic ksa_busy(input ksa_state_t st);
    return (st != ST_IDLE) && (st != ST_DONE);
  endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Control handshake and S-memory port of the RC4 KSA engine.
// master = engine side, slave = controller/memory side.
interface rc4_ksa_engine_if import rc4_pkg::*; #(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
);

  logic                   start;
  logic [KEY_BYTES*8-1:0] secret_key;
  logic [7:0]             s_q;
  logic [7:0]             s_address;
  logic [7:0]             s_data;
  logic                   s_wren;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, secret_key, s_q,
    output s_address, s_data, s_wren, busy, done
  );

  modport slave (
    output start, secret_key, s_q,
    input  s_address, s_data, s_wren, busy, done
  );

endinterface

// File: rtl/rc4_ksa_engine_key_byte_sel.sv
// Combinational pick of key byte k; byte 0 is the most significant byte
// of secret_key.
module rc4_key_byte_sel import rc4_pkg::*; #(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [KW-1:0]          k,
  output key_byte_t              key_byte
);

  // Priority-free mux over the key bytes; k never exceeds KEY_BYTES-1.
  always_comb begin
    key_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      key_byte = (k == KW'(n)) ? secret_key[(KEY_BYTES-1-n)*8 +: 8] : key_byte;
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of S, then the KSA shuffle.
// Define RC4_KSA_FILL_EN to include the FILL phase; otherwise S must be preloaded.
module rc4_ksa_engine import rc4_pkg::*; #(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  rc4_ksa_engine_if.master bus
);

  localparam int              KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(KEY_BYTES - 1);
  localparam logic [7:0]      I_LAST = 8'(S_SIZE - 1);
`ifdef RC4_KSA_FILL_EN
  localparam ksa_state_t      START_STATE = ST_FILL;
`else
  localparam ksa_state_t      START_STATE = ST_RD_I;
`endif

  ksa_state_t    state_r, state_s;
  logic [7:0]    i_r, i_s;
  logic [7:0]    j_r, j_s;
  logic [KW-1:0] k_r, k_s;
  logic [7:0]    si_r, si_s;
  logic [7:0]    sj_r, sj_s;
  logic [7:0]    addr_r, addr_s;
  logic [7:0]    data_r, data_s;
  logic          wren_r, wren_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  key_byte_t     key_byte_s;

  rc4_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KW        (KW)
  ) u_key_sel (
    .secret_key (bus.secret_key),
    .k          (k_r),
    .key_byte   (key_byte_s)
  );

  // Next-state logic, then the memory-port/status decode of the next state so
  // the outputs can be registered without adding a cycle of latency.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    k_s     = k_r;
    si_s    = si_r;
    sj_s    = sj_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_s = START_STATE;
          i_s     = 8'h00;
          j_s     = 8'h00;
          k_s     = {KW{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      ST_FILL: begin
        if (i_r == I_LAST) begin
          state_s = ST_RD_I;
          i_s     = 8'h00;
        end else begin
          i_s     = i_r + 8'h01;
        end
      end
      ST_RD_I:  state_s = ST_WT_I;
      ST_WT_I:  state_s = ST_CAP_I;
      ST_CAP_I: begin
        si_s    = bus.s_q;
        j_s     = j_r + bus.s_q + key_byte_s;
        state_s = ST_RD_J;
      end
      ST_RD_J:  state_s = ST_WT_J;
      ST_WT_J:  state_s = ST_CAP_J;
      ST_CAP_J: begin
        sj_s    = bus.s_q;
        state_s = ST_WR_J;
      end
      ST_WR_J:  state_s = ST_WR_I;
      ST_WR_I: begin
        if (i_r == I_LAST) begin
          state_s = ST_DONE;
        end else begin
          i_s     = i_r + 8'h01;
          k_s     = (k_r == K_LAST) ? {KW{1'b0}} : k_r + KW'(1);
          state_s = ST_RD_I;
        end
      end
      default:  state_s = ST_IDLE;
    endcase

    addr_s = 8'h00;
    data_s = 8'h00;
    wren_s = 1'b0;
    case (state_s)
      ST_FILL: begin
        addr_s = i_s;
        data_s = i_s;
        wren_s = 1'b1;
      end
      // Hold the read address through the wait/capture cycles so s_q stays valid.
      ST_RD_I, ST_WT_I, ST_CAP_I: addr_s = i_s;
      ST_RD_J, ST_WT_J, ST_CAP_J: addr_s = j_s;
      ST_WR_J: begin
        addr_s = j_s;
        data_s = si_s;
        wren_s = 1'b1;
      end
      ST_WR_I: begin
        addr_s = i_s;
        data_s = sj_s;
        wren_s = 1'b1;
      end
      default: addr_s = 8'h00;
    endcase
    busy_s = ksa_busy(state_s);
    done_s = (state_s == ST_DONE);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      i_r     <= 8'h00;
      j_r     <= 8'h00;
      k_r     <= {KW{1'b0}};
      si_r    <= 8'h00;
      sj_r    <= 8'h00;
      addr_r  <= 8'h00;
      data_r  <= 8'h00;
      wren_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      j_r     <= j_s;
      k_r     <= k_s;
      si_r    <= si_s;
      sj_r    <= sj_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      wren_r  <= wren_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.s_address = addr_r;
  assign bus.s_data    = data_r;
  assign bus.s_wren    = wren_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench for rc4_ksa_engine: synchronous S-memory model, an
// abstract KSA reference producing the expected write stream, per-cycle compare.
module tb_rc4_ksa_engine;
  import rc4_pkg::*;

`ifdef RC4_KSA_FILL_EN
  localparam int NFILL = 256;
`else
  localparam int NFILL = 0;
`endif
  localparam int RUN_LEN  = NFILL + 8 * 256;
  localparam int ABORT_AT = (NFILL != 0) ? 40 : 8 * 40;

  typedef struct {
    int at;
    int addr;
    int data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rc4_ksa_engine_if #(.KEY_BYTES(3)) bus ();

  rc4_ksa_engine #(.KEY_BYTES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_cnt  = 0;
  int   e0       = 0;
  logic run_active = 1'b0;
  logic preload    = 1'b0;

  logic [7:0] mem [256];
  int         model_s [256];
  wr_t        exp_q [$];
  int         wr_log_addr [$];
  int         wr_log_data [$];
  int         cmp_el;
  logic       cmp_w;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Synchronous S memory: one-cycle read latency, write on s_wren.
  always @(posedge clk) begin
    if (preload) begin
      for (int n = 0; n < 256; n++) mem[n] <= (NFILL != 0) ? (8'(n) ^ 8'hA5) : 8'(n);
    end else if (bus.s_wren) begin
      mem[bus.s_address] <= bus.s_data;
    end
    bus.s_q <= mem[bus.s_address];
  end

  // Plain KSA over an array; emits the expected (cycle, addr, data) write stream.
  task automatic build_model(input logic [23:0] key, input int iters);
    int j;
    int t;
    int kb [3];
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    exp_q.delete();
    for (int n = 0; n < NFILL; n++) exp_q.push_back(wr_t'{n, n, n});
    for (int n = 0; n < 256; n++) model_s[n] = n;
    j = 0;
    for (int i = 0; i < iters; i++) begin
      j = (j + model_s[i] + kb[i % 3]) % 256;
      exp_q.push_back(wr_t'{NFILL + 8 * i + 6, j, model_s[i]});
      exp_q.push_back(wr_t'{NFILL + 8 * i + 7, i, model_s[j]});
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endtask

  // Per-cycle compare of status and memory writes against the model stream.
  always @(posedge clk) begin
    #2;
    if (run_active) begin
      cmp_el = cyc_cnt - e0;
      if (cmp_el >= 0) begin
        check("busy", int'(bus.busy), (cmp_el < RUN_LEN) ? 1 : 0);
        check("done", int'(bus.done), (cmp_el >= RUN_LEN) ? 1 : 0);
        cmp_w = (exp_q.size() > 0) && (exp_q[0].at == cmp_el);
        check("s_wren", int'(bus.s_wren), cmp_w ? 1 : 0);
        if (cmp_w) begin
          if (bus.s_wren) begin
            check("s_address", int'(bus.s_address), exp_q[0].addr);
            check("s_data", int'(bus.s_data), exp_q[0].data);
            wr_log_addr.push_back(int'(bus.s_address));
            wr_log_data.push_back(int'(bus.s_data));
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic launch(input logic [23:0] key);
    @(negedge clk);
    run_active = 1'b0;
    preload    = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    build_model(key, 256);
    wr_log_addr.delete();
    wr_log_data.delete();
    bus.secret_key = key;
    bus.start      = 1'b1;
    e0             = cyc_cnt + 1;
    run_active     = 1'b1;
    @(posedge clk);
    #2;
    check("start_addr", int'(bus.s_address), 0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_run(input int glitch_at, input string tag);
    int done_at;
    done_at = -1;
    for (int c = 0; c < RUN_LEN + 50 && done_at < 0; c++) begin
      @(negedge clk);
      bus.start = (glitch_at >= 0 && (cyc_cnt - e0) == glitch_at) ? 1'b1 : 1'b0;
      if (bus.done) done_at = cyc_cnt - e0;
    end
    bus.start = 1'b0;
    check({tag, "_done_cycle"}, done_at, RUN_LEN);
    repeat (3) @(negedge clk);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    for (int n = 0; n < 256; n++) begin
      check($sformatf("%s_S[%0d]", tag, n), int'(mem[n]), model_s[n]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit_a [6];
    int lit_d [6];
    lit_a = '{0, 0, 1, 1, 3, 2};
    lit_d = '{0, 0, 1, 1, 2, 3};
    bus.start      = 1'b0;
    bus.secret_key = 24'h000000;

    repeat (3) @(negedge clk);
    check("rst_s_address", int'(bus.s_address), 0);
    check("rst_s_data", int'(bus.s_data), 0);
    check("rst_s_wren", int'(bus.s_wren), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    reset = 1'b0;

    // Hand-computed KSA steps pin the reference model.
    build_model(24'h000000, 3);
    check("model_k0_S2", model_s[2], 3);
    check("model_k0_S3", model_s[3], 2);
    check("model_k0_S0", model_s[0], 0);
    build_model(24'h000249, 3);
    check("model_k249_S1", model_s[1], 3);
    check("model_k249_S3", model_s[3], 1);
    check("model_k249_S2", model_s[2], 78);
    check("model_k249_S78", model_s[78], 2);

    // Abort a run part-way through with an asynchronous reset.
    launch(24'h000000);
    while ((cyc_cnt - e0) < ABORT_AT) @(negedge clk);
    run_active = 1'b0;
    reset      = 1'b1;
    #1;
    check("abort_s_address", int'(bus.s_address), 0);
    check("abort_s_data", int'(bus.s_data), 0);
    check("abort_s_wren", int'(bus.s_wren), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    @(posedge clk);
    #1;
    check("abort_next_busy", int'(bus.busy), 0);
    check("abort_next_wren", int'(bus.s_wren), 0);
    check("abort_next_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;

    launch(24'h000000);
    finish_run(-1, "k000000");
    check("k0_log_size", wr_log_addr.size(), NFILL + 512);
    if (wr_log_addr.size() >= NFILL + 6) begin
      for (int n = 0; n < 6; n++) begin
        check($sformatf("k0_wr%0d_addr", n), wr_log_addr[NFILL + n], lit_a[n]);
        check($sformatf("k0_wr%0d_data", n), wr_log_data[NFILL + n], lit_d[n]);
      end
    end

    launch(24'h000249);
    finish_run(500, "k000249");

    launch(24'h3FFFFF);
    finish_run(-1, "k3fffff");

    run_active = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
# rc4_ksa_engine

RC4 key-scheduling stage that sits directly upstream of the decryption state machine. On each `start` it fills the shared 256-byte S memory with the identity permutation, then runs the KSA shuffle with the current 24-bit secret key. It raises `done` when S is ready for the PRGA/decrypt stage. The key-search controller re-triggers it each time the decrypt stage rejects a key.

## Interface
- `KEY_BYTES`, default 3: secret key length in bytes; key byte 0 is the most significant byte of `secret_key`.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin a KSA run; sampled only in IDLE or DONE.
- `secret_key` in KEY_BYTES*8: key; held stable by the producer while `busy`.
- `s_q` in 8: S memory read data; valid in the cycle after the address cycle.
- `s_address` out 8: S memory address.
- `s_data` out 8: S memory write data.
- `s_wren` out 1: S memory write enable.
- `busy` out 1: high from `start` acceptance until DONE is entered.
- `done` out 1: level, high in DONE until the next accepted `start` or `reset`.

## Operation
- States: IDLE, FILL, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J, WR_J, WR_I, DONE.
- IDLE/DONE + `start` → FILL. Clear i=0, j=0, key index k=0, and drop `done`.
- FILL writes address i, data i, `s_wren`=1, one byte per cycle. When i==255, i wraps to 0 → RD_I.
- RD_I: drive address i.
- WT_I: wait one cycle.
- CAP_I: si←s_q; j←j+s_q+key[k] (8-bit wrap).
- RD_J: drive address j (new value).
- WT_J: wait one cycle.
- CAP_J: sj←s_q.
- WR_J: address j, data si, `s_wren`=1.
- WR_I: address i, data sj, `s_wren`=1.
  - If i==255 → DONE.
  - Else i←i+1; k←(k==KEY_BYTES-1)?0:k+1; → RD_I.
- key[k] = `secret_key[(KEY_BYTES-1-k)*8 +: 8]`. Use a wrapping counter, not a modulo divider.
- i==j: both writes carry the same value. S is unchanged, which is correct; no special case.
- `start` while busy is ignored.
- `secret_key` is sampled every CAP_I, so the producer must hold it stable for the whole run.
- Outputs are decoded from state and internal registers only. There is no combinational path from `start`/`s_q` to outputs.

## Timing
- Reset values: `s_address`=0, `s_data`=0, `s_wren`=0, `busy`=0, `done`=0, state IDLE, i=j=k=0.
- Reset mid-run returns to IDLE immediately. S contents are then undefined; a new `start` is required.
- Memory read latency: the address is driven in cycle c, and `s_q` is captured at the end of cycle c+1.
- Start accepted at edge E0:
  - FILL occupies 256 cycles.
  - Shuffle occupies 8 cycles per i, 2048 cycles total.
  - DONE, `done`=1, `busy`=0 from edge E0+2304.
- `start` in DONE re-runs the block. `done` falls on the acceptance edge.
- `s_wren` is high only in FILL, WR_J and WR_I.

## Configuration
- `RC4_KSA_FILL_EN` defined: the FILL phase is present as above.
- Undefined: FILL is removed and `start` goes straight to RD_I. S must already hold the identity permutation, written by an external initialiser. DONE is reached at edge E0+2048.

## Structure
- Package `rc4_pkg` holds:
  - the state enum typedef `ksa_state_t`;
  - `S_SIZE`=256;
  - `KEY_BYTES_DEFAULT`=3;
  - the `key_byte_t` typedef (logic [7:0]).
- One sub-module, `rc4_key_byte_sel`: combinational selection of key byte k from `secret_key`, parameterised by KEY_BYTES.

## Test plan
- Reset mid-FILL at i=40 → all outputs 0 and IDLE next cycle. A new `start` restarts at address 0.
- FILL check (macro defined): after FILL, S[n]=n for all n. Write sequence is addresses 0..255, each with `s_wren`=1 for exactly one cycle.
- Key 24'h000000, third iteration (i=2): j=3. Expect write (addr 3, data 2) followed by (addr 2, data 3). Iterations i=0 and i=1 write identical values back.
- Key 24'h000249, full run vs. C reference model:
  - final S matches byte-for-byte;
  - `done` rises exactly 2304 cycles after `start` (2048 with the macro undefined).
- `start` pulsed at cycle 500 while busy → ignored, completion cycle unchanged.
- After `done`: change the key to 24'h3FFFFF and pulse `start` → `done` drops, the run repeats, and the final S matches the model for the new key.
